// File: rtl/i2c_to_nitta_collector.sv
// Receive-side I2C-to-NITTA glue: gathers I2C bytes MSB-first into one NITTA word
// and strobes it out; an I2C start condition resynchronises the byte counter.
module i2c_to_nitta_collector #(
   parameter int DATA_WIDTH     = 32,
   parameter int ATTR_WIDTH     = 4,
   parameter int I2C_DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i2c_ready,
   input  logic [I2C_DATA_WIDTH-1:0] from_i2c,
   input  logic                      i2c_frame_start,
   output logic [DATA_WIDTH-1:0]     to_nitta,
   output logic                      collector_ready,
   output logic                      err_partial
);

   localparam int SUBFRAME_NUMBER = DATA_WIDTH / I2C_DATA_WIDTH;
   localparam int CNT_W           = $clog2(SUBFRAME_NUMBER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SUBFRAME_NUMBER - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Reject parameter sets that cannot form a whole multi-byte word.
   generate
      if ((DATA_WIDTH % I2C_DATA_WIDTH) != 0) begin : g_bad_ratio
         $error("DATA_WIDTH must be a multiple of I2C_DATA_WIDTH");
      end
      if (SUBFRAME_NUMBER < 2) begin : g_bad_count
         $error("a NITTA word must span at least two I2C bytes");
      end
      if (ATTR_WIDTH < 1) begin : g_bad_attr
         $error("ATTR_WIDTH must be positive");
      end
   endgenerate

   logic                  armed_q, armed_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0] to_nitta_q, to_nitta_d;
   logic                  ready_q, ready_d;
   logic                  err_q, err_d;

   logic                  accept_s;
   logic [CNT_W-1:0]      cnt_base_s;
   logic [DATA_WIDTH-1:0] acc_base_s;
   logic [DATA_WIDTH-1:0] shifted_s;

   // Next-state logic: a start condition rebases the word before any same-edge byte lands.
   always_comb begin
      armed_d    = armed_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      to_nitta_d = to_nitta_q;
      ready_d    = 1'b0;
      err_d      = 1'b0;
      accept_s   = armed_q & i2c_ready;
      cnt_base_s = cnt_q;
      acc_base_s = acc_q;

      if (!i2c_ready) begin
         armed_d = 1'b1;
      end else if (accept_s) begin
         armed_d = 1'b0;
      end else begin
         armed_d = armed_q;
      end

      if (i2c_frame_start) begin
         cnt_base_s = CNT_ZERO;
         acc_base_s = {DATA_WIDTH{1'b0}};
         err_d      = (cnt_q != CNT_ZERO);
      end else begin
         cnt_base_s = cnt_q;
         acc_base_s = acc_q;
         err_d      = 1'b0;
      end

      shifted_s = {acc_base_s[DATA_WIDTH-I2C_DATA_WIDTH-1:0], from_i2c};

      if (accept_s) begin
         acc_d = shifted_s;
         if (cnt_base_s == CNT_LAST) begin
            to_nitta_d = shifted_s;
            cnt_d      = CNT_ZERO;
            ready_d    = 1'b1;
         end else begin
            cnt_d      = cnt_base_s + CNT_ONE;
            ready_d    = 1'b0;
         end
      end else begin
         acc_d = acc_base_s;
         cnt_d = cnt_base_s;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed_q    <= 1'b0;
         cnt_q      <= CNT_ZERO;
         acc_q      <= {DATA_WIDTH{1'b0}};
         to_nitta_q <= {DATA_WIDTH{1'b0}};
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         armed_q    <= armed_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         to_nitta_q <= to_nitta_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
      end
   end

   assign to_nitta        = to_nitta_q;
   assign collector_ready = ready_q;
   assign err_partial     = err_q;

endmodule

// File: doc/i2c_to_nitta_collector.md
# i2c_to_nitta_collector

Receive-side glue between the I2C slave and the NITTA processor bus. Collects consecutive I2C bytes into one NITTA data word, most significant byte first, and presents the completed word with a one-cycle strobe. It is the counterpart of the transmit-side splitter and uses the same `i2c_ready` level handshake, so a word sent by the splitter is rebuilt bit-exact here. An I2C start condition resynchronises the byte counter, and the block flags any partial word it discards.

## Interface
- `DATA_WIDTH`, 32, NITTA word width; must be an integer multiple of `I2C_DATA_WIDTH`.
- `ATTR_WIDTH`, 4, NITTA attribute width; carried for bus uniformity, unused inside.
- `I2C_DATA_WIDTH`, 8, I2C byte width.
- `SUBFRAME_NUMBER` (local), `DATA_WIDTH / I2C_DATA_WIDTH`; must be ≥ 2.

- `clk` input 1: single clock.
- `rst` input 1: asynchronous reset, active-high; clears all state immediately.
- `i2c_ready` input 1: level from the I2C slave; each low-to-high episode delivers one byte.
- `from_i2c` input `I2C_DATA_WIDTH`: byte data, valid whenever `i2c_ready` is high.
- `i2c_frame_start` input 1: one-cycle pulse on an I2C start condition.
- `to_nitta` output `DATA_WIDTH`: last completed word, held until the next word completes.
- `collector_ready` output 1: one-cycle pulse when `to_nitta` has just been updated.
- `err_partial` output 1: one-cycle pulse when a start condition discards a partial word.

## Operation
- State:
  - `armed` flag;
  - byte counter `cnt` (0 .. `SUBFRAME_NUMBER`-1, width `$clog2(SUBFRAME_NUMBER)`);
  - shift register `acc` (`DATA_WIDTH`);
  - output register `to_nitta`.
- Reset (async) clears all of these: `armed`=0, `cnt`=0, `acc`=0, `to_nitta`=0, `collector_ready`=0, `err_partial`=0.
- Arming:
  - `armed` becomes 1 on any clock edge where `i2c_ready`=0.
  - A byte whose `i2c_ready` is already high when reset deasserts is ignored.
- Accept: a byte is accepted on an edge where `armed`=1 and `i2c_ready`=1. On accept:
  - `armed` goes to 0;
  - `acc` shifts to `{acc[DATA_WIDTH-I2C_DATA_WIDTH-1:0], from_i2c}`, so the first byte ends up most significant.
- Counting:
  - If `cnt` < `SUBFRAME_NUMBER`-1, the accept increments `cnt`.
  - If `cnt` = `SUBFRAME_NUMBER`-1, it completes the word: `to_nitta` takes the shifted value (including the current byte), `cnt` wraps to 0, and `collector_ready` pulses.
- Holding `i2c_ready` high for many cycles counts as one byte.
- Start condition (`i2c_frame_start`=1):
  - `cnt` clears to 0 and `acc` clears to 0.
  - If `cnt` was nonzero, `err_partial` pulses.
  - `to_nitta` is unchanged.
- Start condition and accept on the same edge: the start wins first, then the byte is stored as byte 0 of the new word (`cnt` becomes 1, `acc` = zero-extended byte). `err_partial` follows the old `cnt`.
- Reset mid-word drops the partial word. `to_nitta` returns to 0.

## Timing
- All outputs are registered.
- Latency: the last byte is sampled at edge N; `to_nitta` and `collector_ready` are valid after edge N, for cycle N+1 only in the case of the strobe.
- `collector_ready` is never high for two consecutive cycles.
- The minimum byte period is 2 cycles (one cycle high, one cycle low), so the maximum word rate is one word per 2·`SUBFRAME_NUMBER` cycles.
- `err_partial` appears in the cycle after the `i2c_frame_start` edge.
- `to_nitta` is stable between strobes. There is no back-pressure: NITTA must consume the word before the next strobe.

## Test plan
- **Basic word:** after reset, bytes 0x12, 0x34, 0x56, 0x78, each `i2c_ready` high 1 cycle and low 3 cycles.
  - Exactly one `collector_ready` pulse, the cycle after the 0x78 edge.
  - `to_nitta`=0x12345678; `err_partial` stays 0.
- **Level vs. edge:** `i2c_ready` held high 6 cycles with 0xAA, then bytes 0xBB, 0xCC, 0xDD.
  - Word 0xAABBCCDD.
  - A single high episode counts once.
- **Partial + restart:** bytes 0x01, 0x02, then an `i2c_frame_start` pulse, then 0xDE, 0xAD, 0xBE, 0xEF.
  - `err_partial` pulses once.
  - `to_nitta`=0xDEADBEEF; the earlier value is not disturbed before that.
- **Simultaneous events:** after 3 bytes, `i2c_frame_start` and accept of 0x11 on the same edge, then 0x22, 0x33, 0x44.
  - `err_partial` pulses.
  - Word 0x11223344.
- **Async reset:** assert `rst` between clock edges after 2 bytes.
  - `to_nitta`, `collector_ready` and `err_partial` go to 0 immediately.
  - With `i2c_ready` high at deassert, that byte is ignored; the next four bytes form the word.
- **Back-to-back:** two words at the minimum byte period, 0xCAFEBABE then 0x00000001.
  - Two strobes 8 cycles apart with correct values.
  - Loopback through the splitter matches the transmitted word.
